// File: rtl/idecode_pkg.sv
// Shared decode definitions: instruction field positions, ID/EX control bundle
// and the control derivation helpers used by idecode_hz.
package idecode_pkg;

    localparam int WMEM_B    = 31;
    localparam int WREG_B    = 30;
    localparam int RS1_LSB   = 27;
    localparam int RS2_LSB   = 24;
    localparam int RD_LSB    = 21;
    localparam int ALU_LSB   = 17;
    localparam int ALUSRC_B  = 16;
    localparam int BRANCH_B  = 15;
    localparam int BRTYPE_B  = 14;
    localparam int SHIFT_LSB = 6;

    typedef struct packed {
        logic       wreg_en;
        logic       wmem_en;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alusrc;
        logic       branch;
        logic       brtype;
        logic [2:0] rd;
        logic [4:0] shift;
        logic [3:0] alu_ctrl;
    } idex_ctrl_t;

    function automatic logic mem_read_of(input logic wmem_en, input logic wreg_en);
        return ~wmem_en & wreg_en;
    endfunction

    function automatic logic rs2_used(input logic [31:0] inst);
        return ~inst[ALUSRC_B] | inst[WMEM_B] | inst[BRANCH_B];
    endfunction

    function automatic idex_ctrl_t decode_ctrl(input logic [31:0] inst);
        idex_ctrl_t c;
        c.wmem_en    = inst[WMEM_B];
        c.wreg_en    = inst[WREG_B];
        c.mem_read   = mem_read_of(inst[WMEM_B], inst[WREG_B]);
        c.mem_to_reg = c.mem_read;
        c.alusrc     = inst[ALUSRC_B];
        c.branch     = inst[BRANCH_B];
        c.brtype     = inst[BRTYPE_B];
        c.rd         = inst[RD_LSB +: 3];
        c.shift      = inst[SHIFT_LSB +: 5];
        c.alu_ctrl   = inst[ALU_LSB +: 4];
        return c;
    endfunction

    // A bubble must not write anything, touch memory or redirect fetch.
    function automatic idex_ctrl_t kill_ctrl(input idex_ctrl_t c);
        idex_ctrl_t k;
        k            = c;
        k.wreg_en    = 1'b0;
        k.wmem_en    = 1'b0;
        k.mem_read   = 1'b0;
        k.mem_to_reg = 1'b0;
        k.branch     = 1'b0;
        return k;
    endfunction

endpackage

// File: rtl/idecode_regfile.sv
// 8-entry register file, two combinational read ports, one write port.
// Optional write-back bypass on the read ports under IDECODE_WB_BYPASS_EN.
module idecode_regfile #(
    parameter int DATA_W  = 32,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wena,
    input  logic [2:0]        raddr1,
    input  logic [2:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [7:0][DATA_W-1:0] regs;
    logic                   we;

    assign we = wena & ~(R0_ZERO && waddr == 3'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
`ifdef IDECODE_WB_BYPASS_EN
        if (we && waddr == raddr1) rdata1 = wdata;
        if (we && waddr == raddr2) rdata2 = wdata;
`endif
        if (R0_ZERO && raddr1 == 3'd0) rdata1 = '0;
        if (R0_ZERO && raddr2 == 3'd0) rdata2 = '0;
    end

endmodule

// File: rtl/idecode_hz.sv
// Decode stage: field decode, regfile read, registered ID/EX bundle, load-use
// bubble insertion and flush. Build option: IDECODE_WB_BYPASS_EN (regfile bypass).
module idecode_hz
    import idecode_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter bit R0_ZERO  = 1'b1,
    parameter int HZ_CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [31:0]         if_inst,
    output logic                stall_out,
    input  logic                flush_in,
    input  logic                ex_ready,
    input  logic [2:0]          wb_waddr,
    input  logic [DATA_W-1:0]   wb_wdata,
    input  logic                wb_wena,
    output logic                ex_valid,
    output logic [DATA_W-1:0]   ex_r1data,
    output logic [DATA_W-1:0]   ex_r2data,
    output logic [2:0]          ex_rd,
    output logic                ex_wreg_en,
    output logic                ex_wmem_en,
    output logic                ex_mem_read,
    output logic                ex_mem_to_reg,
    output logic                ex_alusrc,
    output logic                ex_branch,
    output logic                ex_brtype,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [4:0]          ex_shift,
    output logic [3:0]          ex_alu_ctrl,
    output logic [HZ_CNT_W-1:0] hz_count
);

    logic [2:0]        rs1, rs2;
    logic [DATA_W-1:0] r1, r2, imm;
    logic signed [11:0] imm12;
    idex_ctrl_t        dec, ex_ctrl;
    logic              rs1_hit, rs2_hit, hazard, issue;

    assign rs1   = if_inst[RS1_LSB +: 3];
    assign rs2   = if_inst[RS2_LSB +: 3];
    assign dec   = decode_ctrl(if_inst);
    assign imm12 = if_inst[11:0];
    assign imm   = DATA_W'(imm12);

    idecode_regfile #(.DATA_W(DATA_W), .R0_ZERO(R0_ZERO)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .waddr  (wb_waddr),
        .wdata  (wb_wdata),
        .wena   (wb_wena),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (r1),
        .rdata2 (r2)
    );

    // A pending load into r0 never produces a value worth waiting for.
    assign rs1_hit = (ex_ctrl.rd == rs1) && !(R0_ZERO && rs1 == 3'd0);
    assign rs2_hit = rs2_used(if_inst) && (ex_ctrl.rd == rs2) && !(R0_ZERO && rs2 == 3'd0);
    assign hazard  = if_valid & ex_valid & ex_ctrl.mem_read & ex_ctrl.wreg_en & (rs1_hit | rs2_hit);
    assign issue   = if_valid & ~flush_in & ~hazard;

    assign stall_out = rst & (~ex_ready | (~flush_in & hazard));

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_r1data <= '0;
            ex_r2data <= '0;
            ex_imm    <= '0;
            hz_count  <= '0;
        end else if (ex_ready) begin
            ex_valid  <= issue;
            ex_ctrl   <= issue ? dec : kill_ctrl(dec);
            ex_r1data <= r1;
            ex_r2data <= r2;
            ex_imm    <= imm;
            if (~flush_in & hazard & ~&hz_count)
                hz_count <= hz_count + {{(HZ_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ex_rd         = ex_ctrl.rd;
    assign ex_wreg_en    = ex_ctrl.wreg_en;
    assign ex_wmem_en    = ex_ctrl.wmem_en;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_alusrc     = ex_ctrl.alusrc;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_brtype     = ex_ctrl.brtype;
    assign ex_shift      = ex_ctrl.shift;
    assign ex_alu_ctrl   = ex_ctrl.alu_ctrl;

endmodule

// File: tb/tb_idecode_hz.sv
// Directed bench for idecode_hz; small hazard counter so saturation is reachable.
module tb_idecode_hz;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush_in, ex_ready, wb_wena, stall_out;
    logic [31:0] if_inst, wb_wdata;
    logic [2:0]  wb_waddr;
    logic        ex_valid, ex_wreg_en, ex_wmem_en, ex_mem_read, ex_mem_to_reg;
    logic        ex_alusrc, ex_branch, ex_brtype;
    logic [31:0] ex_r1data, ex_r2data, ex_imm;
    logic [2:0]  ex_rd;
    logic [4:0]  ex_shift;
    logic [3:0]  ex_alu_ctrl;
    logic [1:0]  hz_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    idecode_hz #(.DATA_W(32), .R0_ZERO(1'b1), .HZ_CNT_W(2)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst),
        .stall_out(stall_out), .flush_in(flush_in), .ex_ready(ex_ready),
        .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_wena(wb_wena),
        .ex_valid(ex_valid), .ex_r1data(ex_r1data), .ex_r2data(ex_r2data),
        .ex_rd(ex_rd), .ex_wreg_en(ex_wreg_en), .ex_wmem_en(ex_wmem_en),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_brtype(ex_brtype),
        .ex_imm(ex_imm), .ex_shift(ex_shift), .ex_alu_ctrl(ex_alu_ctrl),
        .hz_count(hz_count)
    );

    function automatic logic [31:0] mk(input logic wmem, input logic wreg,
                                       input logic [2:0] s1, input logic [2:0] s2,
                                       input logic [2:0] rd, input logic alusrc,
                                       input logic br, input logic [11:0] imm);
        return {wmem, wreg, s1, s2, rd, 4'h0, alusrc, br, 1'b0, 2'b00, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        wb_wena = 1'b1; wb_waddr = a; wb_wdata = d;
        step();
        wb_wena = 1'b0;
    endtask

    task automatic drain();
        if_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; if_valid = 1'b1; if_inst = 32'h4A200005;
        step(); step();
        n_vec++;
        if ({ex_valid, stall_out, hz_count, ex_wreg_en, ex_mem_read} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got v=%b st=%b hz=%0d we=%b mr=%b want all 0",
                     ex_valid, stall_out, hz_count, ex_wreg_en, ex_mem_read);
        end
        n_vec++;
        if ({ex_r1data, ex_r2data, ex_imm} !== 96'h0) begin
            n_err++;
            $display("FAIL reset_data got r1=%h r2=%h imm=%h want 0", ex_r1data, ex_r2data, ex_imm);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_inst = mk(1'b0, 1'b0, 3'(i), 3'(7 - i), 3'd0, 1'b0, 1'b0, 12'h0);
            step();
            n_vec++;
            if ({ex_valid, ex_r1data, ex_r2data} !== {1'b1, 64'h0}) begin
                n_err++;
                $display("FAIL reset_regs[%0d] got v=%b r1=%h r2=%h want v=1 r1=0 r2=0",
                         i, ex_valid, ex_r1data, ex_r2data);
            end
        end
        drain();
    endtask

    task automatic test_normal();
        if_valid = 1'b1; if_inst = 32'h4A200005;
        step();
        n_vec++;
        if ({ex_valid, ex_rd, ex_imm, ex_r1data, ex_r2data} !== {1'b1, 3'd1, 32'd5, 32'h11, 32'h22}) begin
            n_err++;
            $display("FAIL normal_bundle got v=%b rd=%0d imm=%h r1=%h r2=%h want v=1 rd=1 imm=5 r1=11 r2=22",
                     ex_valid, ex_rd, ex_imm, ex_r1data, ex_r2data);
        end
        // wmem=0, wreg=1 derives mem_read=mem_to_reg=1
        n_vec++;
        if ({ex_wreg_en, ex_wmem_en, ex_mem_read, ex_mem_to_reg, ex_alusrc} !== 5'b10110) begin
            n_err++;
            $display("FAIL normal_ctrl got %b want 10110",
                     {ex_wreg_en, ex_wmem_en, ex_mem_read, ex_mem_to_reg, ex_alusrc});
        end
        if_inst = 32'h0015C7C0;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++;
            $display("FAIL normal_nostall got %b want 0", stall_out);
        end
        step();
        n_vec++;
        if ({ex_alu_ctrl, ex_alusrc, ex_branch, ex_brtype, ex_shift, ex_imm, ex_mem_read, ex_wreg_en}
            !== {4'hA, 3'b111, 5'd31, 32'h7C0, 2'b00}) begin
            n_err++;
            $display("FAIL fields got alu=%h as=%b br=%b bt=%b sh=%0d imm=%h mr=%b we=%b want A 1 1 1 31 7c0 0 0",
                     ex_alu_ctrl, ex_alusrc, ex_branch, ex_brtype, ex_shift, ex_imm, ex_mem_read, ex_wreg_en);
        end
        if_inst = mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 12'h800);
        step();
        n_vec++;
        if ({ex_imm, ex_shift} !== {32'hFFFFF800, 5'd0}) begin
            n_err++;
            $display("FAIL sign_ext got imm=%h sh=%0d want fffff800 0", ex_imm, ex_shift);
        end
        drain();
    endtask

    task automatic test_load_use();
        if_valid = 1'b1;
        if_inst = mk(1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 12'h0);
        step();
        if_inst = mk(1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 12'h0);
        #1;
        n_vec++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL lu_rs1_stall got %b want 1", stall_out);
        end
        step();
        n_vec++;
        if ({ex_valid, ex_wreg_en, ex_mem_read, hz_count} !== {3'b000, 2'd1}) begin
            n_err++;
            $display("FAIL lu_bubble got v=%b we=%b mr=%b hz=%0d want 0 0 0 1",
                     ex_valid, ex_wreg_en, ex_mem_read, hz_count);
        end
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL lu_release got %b want 0", stall_out);
        end
        step();
        n_vec++;
        if ({ex_valid, ex_r1data, hz_count} !== {1'b1, 32'h33, 2'd1}) begin
            n_err++;
            $display("FAIL lu_issue got v=%b r1=%h hz=%0d want 1 33 1", ex_valid, ex_r1data, hz_count);
        end
        if_inst = mk(1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 12'h0);
        step();
        if_inst = mk(1'b0, 1'b0, 3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 12'h0);
        #1;
        n_vec++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL lu_rs2_stall got %b want 1", stall_out);
        end
        step(); step();
        n_vec++;
        if ({ex_valid, ex_r2data, hz_count} !== {1'b1, 32'h44, 2'd2}) begin
            n_err++;
            $display("FAIL lu_rs2_issue got v=%b r2=%h hz=%0d want 1 44 2", ex_valid, ex_r2data, hz_count);
        end
        // rs2 matches but is not read (alusrc=1, no store/branch)
        if_inst = mk(1'b0, 1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b0, 12'h0);
        step();
        if_inst = mk(1'b0, 1'b0, 3'd0, 3'd4, 3'd0, 1'b1, 1'b0, 12'h0);
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL lu_rs2_unused got %b want 0", stall_out);
        end
        step();
        if_inst = mk(1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 12'h0);
        step();
        if_inst = mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 12'h0);
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL lu_r0 got %b want 0", stall_out);
        end
        step();
        n_vec++;
        if ({ex_valid, hz_count} !== {1'b1, 2'd2}) begin
            n_err++; $display("FAIL lu_r0_issue got v=%b hz=%0d want 1 2", ex_valid, hz_count);
        end
        drain();
    endtask

    task automatic test_stall();
        if_valid = 1'b1;
        if_inst = mk(1'b0, 1'b0, 3'd1, 3'd0, 3'd5, 1'b1, 1'b0, 12'h123);
        step();
        ex_ready = 1'b0;
        if_inst = mk(1'b0, 1'b0, 3'd2, 3'd0, 3'd6, 1'b1, 1'b0, 12'h456);
        for (int k = 0; k < 3; k++) begin
            flush_in = (k == 1);
            #1;
            n_vec++;
            if (stall_out !== 1'b1) begin
                n_err++; $display("FAIL stall_out[%0d] got %b want 1", k, stall_out);
            end
            step();
            n_vec++;
            if ({ex_valid, ex_rd, ex_imm, ex_r1data} !== {1'b1, 3'd5, 32'h123, 32'h11}) begin
                n_err++;
                $display("FAIL stall_hold[%0d] got v=%b rd=%0d imm=%h r1=%h want 1 5 123 11",
                         k, ex_valid, ex_rd, ex_imm, ex_r1data);
            end
        end
        ex_ready = 1'b1; flush_in = 1'b0;
        step();
        n_vec++;
        if ({ex_valid, ex_rd, ex_imm, ex_r1data} !== {1'b1, 3'd6, 32'h456, 32'h22}) begin
            n_err++;
            $display("FAIL stall_resume got v=%b rd=%0d imm=%h r1=%h want 1 6 456 22",
                     ex_valid, ex_rd, ex_imm, ex_r1data);
        end
    endtask

    task automatic test_flush();
        if_inst = mk(1'b0, 1'b0, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0, 12'h0);
        flush_in = 1'b1;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL flush_stall got %b want 0", stall_out);
        end
        step();
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_valid got %b want 0", ex_valid);
        end
        flush_in = 1'b0;
        if_inst = mk(1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 12'h0);
        step();
        if_inst = mk(1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 12'h0);
        flush_in = 1'b1;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL flush_over_hz got %b want 0", stall_out);
        end
        step();
        n_vec++;
        if ({ex_valid, hz_count} !== {1'b0, 2'd2}) begin
            n_err++; $display("FAIL flush_hz_count got v=%b hz=%0d want 0 2", ex_valid, hz_count);
        end
        flush_in = 1'b0;
        drain();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_r1;
`ifdef IDECODE_WB_BYPASS_EN
        exp_r1 = 32'hDEADBEEF;
`else
        exp_r1 = 32'h22;
`endif
        if_valid = 1'b1;
        if_inst = mk(1'b0, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 12'h0);
        wb_wena = 1'b1; wb_waddr = 3'd2; wb_wdata = 32'hDEADBEEF;
        step();
        wb_wena = 1'b0;
        n_vec++;
        if (ex_r1data !== exp_r1) begin
            n_err++; $display("FAIL bypass_same got %h want %h", ex_r1data, exp_r1);
        end
        step();
        n_vec++;
        if (ex_r1data !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL bypass_next got %h want deadbeef", ex_r1data);
        end
        if_inst = mk(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 12'h0);
        wb_wena = 1'b1; wb_waddr = 3'd0; wb_wdata = 32'h55;
        step();
        wb_wena = 1'b0;
        step();
        n_vec++;
        if ({ex_r1data, ex_r2data} !== 64'h0) begin
            n_err++; $display("FAIL r0_write got r1=%h r2=%h want 0 0", ex_r1data, ex_r2data);
        end
        drain();
    endtask

    task automatic test_hz_saturate();
        if_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_inst = mk(1'b0, 1'b1, 3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 12'h0);
            step();
            if_inst = mk(1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 12'h0);
            step();
            n_vec++;
            if ({ex_valid, hz_count} !== {1'b0, 2'd3}) begin
                n_err++; $display("FAIL hz_sat[%0d] got v=%b hz=%0d want 0 3", k, ex_valid, hz_count);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_stall();
        ex_ready = 1'b0;
        #1;
        n_vec++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL mid_pre got %b want 1", stall_out);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_stall got %b want 0", stall_out);
        end
        step();
        n_vec++;
        if ({ex_valid, stall_out, hz_count} !== 4'b0) begin
            n_err++;
            $display("FAIL mid_rst_state got v=%b st=%b hz=%0d want 0 0 0", ex_valid, stall_out, hz_count);
        end
        rst = 1'b1; ex_ready = 1'b1;
        if_inst = mk(1'b0, 1'b0, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 12'h0);
        step();
        n_vec++;
        if ({ex_valid, ex_r1data, ex_r2data} !== {1'b1, 64'h0}) begin
            n_err++;
            $display("FAIL mid_rst_regs got v=%b r1=%h r2=%h want 1 0 0", ex_valid, ex_r1data, ex_r2data);
        end
    endtask

    initial begin
        rst = 1'b0; if_valid = 1'b0; if_inst = '0; flush_in = 1'b0; ex_ready = 1'b1;
        wb_wena = 1'b0; wb_waddr = '0; wb_wdata = '0;
        test_reset();
        write_reg(3'd1, 32'h11);
        write_reg(3'd2, 32'h22);
        write_reg(3'd3, 32'h33);
        write_reg(3'd4, 32'h44);
        test_normal();
        test_load_use();
        test_stall();
        test_flush();
        test_bypass();
        test_hz_saturate();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no end of run want finish");
        $fatal(1, "timeout");
    end

endmodule
